// File: rtl/ccff_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ccff_pkg
//  Purpose  : Shared types, constants and the CRC-16-CCITT bit-step helper
//             for the configuration-chain (ccff) loader.
//  Contents : ccff_state_e   - loader FSM state encoding (2 bits)
//             CRC_POLY        - CRC-16-CCITT polynomial 0x1021
//             CRC_INIT        - CRC seed 0xFFFF
//             crc16_step()    - absorb one bit, MSB-first
//  Revision : 1.0 - initial release
// ============================================================================
package ccff_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_VERIFY = 2'd2,
        S_DONE   = 2'd3
    } ccff_state_e;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    // One bit-serial step: the incoming bit is XORed with the register MSB
    // and the polynomial is applied when that feedback bit is set.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        logic fb;
        fb = crc[15] ^ din;
        return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ccff_chain_loader_crc.sv
`default_nettype none
// ============================================================================
//  Module   : ccff_crc16
//  Purpose  : Bit-serial CRC-16-CCITT register, MSB-first.
//  Ports    : clk        in   clock
//             rst        in   synchronous active-high reset (to seed)
//             i_init     in   reload seed 0xFFFF (wins over i_en)
//             i_en       in   absorb i_bit this cycle
//             i_bit      in   serial data bit
//             o_crc      out  current CRC register
//             o_crc_next out  CRC value after absorbing i_bit
//  Revision : 1.0 - initial release
// ============================================================================
module ccff_crc16
    import ccff_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_init,
    input  logic        i_en,
    input  logic        i_bit,
    output logic [15:0] o_crc,
    output logic [15:0] o_crc_next
);

    logic [15:0] r_crc;

    // The look-ahead value lets the parent capture a result that includes
    // the bit being absorbed in the same cycle.
    assign o_crc_next = crc16_step(r_crc, i_bit);
    assign o_crc      = r_crc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_crc <= CRC_INIT;
        end else if (i_init) begin
            r_crc <= CRC_INIT;
        end else if (i_en) begin
            r_crc <= o_crc_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ccff_chain_loader.sv
`default_nettype none
// ============================================================================
//  Module   : ccff_chain_loader
//  Purpose  : Writes a configuration bitstream into a ccff chain MSB-first,
//             then rotates the chain once (tail fed back to head) and checks
//             a CRC of the returned bits against the CRC of the loaded bits.
//  Ports    : prog_clk      in   programming clock
//             pReset        in   synchronous active-high reset
//             start         in   one-cycle pulse, accepted only when idle
//             cfg_data      in   host word (WORD_W), MSB shifted first
//             cfg_valid     in   host word valid
//             cfg_ready     out  word accepted this cycle when valid
//             ccff_head     out  serial data into chain head
//             ccff_tail     in   serial data from chain tail
//             ccff_shift_en out  chain advances at the end of this cycle
//             busy          out  LOAD or VERIFY in progress
//             done          out  one-cycle pulse after the verify pass
//             verify_ok     out  CRC match, held until next start
//             verify_err    out  CRC mismatch, held until next start
//  Revision : 1.0 - initial release
// ============================================================================
module ccff_chain_loader
    import ccff_pkg::*;
#(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              ccff_shift_en,
    output logic              busy,
    output logic              done,
    output logic              verify_ok,
    output logic              verify_err
);

    localparam int c_CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int c_WB_W  = $clog2(WORD_W + 1);

    localparam logic [c_CNT_W-1:0] c_LAST      = c_CNT_W'(CHAIN_LEN - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_WB_W-1:0]  c_WORD_BITS = c_WB_W'(WORD_W);
    localparam logic [c_WB_W-1:0]  c_WB_ONE    = c_WB_W'(1);

    ccff_state_e         r_state;
    ccff_state_e         w_state_nxt;
    logic [WORD_W-1:0]   r_shreg;
    logic [WORD_W-1:0]   w_shreg_nxt;
    logic [c_WB_W-1:0]   r_word_bits;
    logic [c_WB_W-1:0]   w_word_bits_nxt;
    logic [c_CNT_W-1:0]  r_bit_cnt;
    logic [c_CNT_W-1:0]  w_bit_cnt_nxt;
    logic                r_shift_en;
    logic                r_busy;
    logic                r_done;
    logic                r_verify_ok;
    logic                r_verify_err;
    logic [15:0]         r_crc_load;

    logic                w_start_ok;
    logic                w_shifting;
    logic                w_last_bit;
    logic                w_ready;
    logic                w_accept;
    logic                w_verify_last;
    logic                w_shift_en_nxt;
    logic                w_crc_init;
    logic                w_crc_en;
    logic                w_crc_bit;
    logic [15:0]         w_crc;
    logic [15:0]         w_crc_next;

    assign w_start_ok    = (r_state == S_IDLE) && start;
    assign w_shifting    = (r_state == S_LOAD) && (r_word_bits != '0);
    assign w_last_bit    = w_shifting && (r_bit_cnt == c_LAST);
    // A new word may land in the same cycle the last bit of the previous one
    // leaves, unless that bit completes the chain (nothing more is wanted).
    assign w_ready       = (r_state == S_LOAD) &&
                           ((r_word_bits == '0) ||
                            ((r_word_bits == c_WB_ONE) && !w_last_bit));
    assign w_accept      = w_ready && cfg_valid;
    assign w_verify_last = (r_state == S_VERIFY) && (r_bit_cnt == c_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_shreg_nxt     = r_shreg;
        w_word_bits_nxt = r_word_bits;
        w_bit_cnt_nxt   = r_bit_cnt;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt     = S_LOAD;
                    w_shreg_nxt     = '0;
                    w_word_bits_nxt = '0;
                    w_bit_cnt_nxt   = '0;
                end
            end
            S_LOAD: begin
                if (w_accept) begin
                    w_shreg_nxt     = cfg_data;
                    w_word_bits_nxt = c_WORD_BITS;
                end else if (w_shifting) begin
                    w_shreg_nxt     = r_shreg << 1;
                    w_word_bits_nxt = r_word_bits - c_WB_ONE;
                end
                if (w_shifting) begin
                    w_bit_cnt_nxt = r_bit_cnt + c_CNT_ONE;
                end
                // Chain full: drop any unshifted low-order bits. Clearing the
                // shift register also parks ccff_head at 0 outside LOAD.
                if (w_last_bit) begin
                    w_state_nxt     = S_VERIFY;
                    w_shreg_nxt     = '0;
                    w_word_bits_nxt = '0;
                    w_bit_cnt_nxt   = '0;
                end
            end
            S_VERIFY: begin
                w_bit_cnt_nxt = r_bit_cnt + c_CNT_ONE;
                if (w_verify_last) begin
                    w_state_nxt   = S_DONE;
                    w_bit_cnt_nxt = '0;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state view so they line up with
    // the state they describe.
    assign w_shift_en_nxt = ((w_state_nxt == S_LOAD) && (w_word_bits_nxt != '0)) ||
                            (w_state_nxt == S_VERIFY);

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            r_shreg      <= '0;
            r_word_bits  <= '0;
            r_bit_cnt    <= '0;
            r_shift_en   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_verify_ok  <= 1'b0;
            r_verify_err <= 1'b0;
            r_crc_load   <= CRC_INIT;
        end else begin
            r_shreg     <= w_shreg_nxt;
            r_word_bits <= w_word_bits_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_shift_en  <= w_shift_en_nxt;
            r_busy      <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_VERIFY);
            r_done      <= (w_state_nxt == S_DONE);
            // The final load bit is absorbed by the look-ahead value, since
            // the shared CRC register is reseeded on this same edge.
            if (w_last_bit) begin
                r_crc_load <= w_crc_next;
            end
            // The comparison result becomes visible together with done.
            if (w_start_ok) begin
                r_verify_ok  <= 1'b0;
                r_verify_err <= 1'b0;
            end else if (w_verify_last) begin
                r_verify_ok  <= (w_crc_next == r_crc_load);
                r_verify_err <= (w_crc_next != r_crc_load);
            end
        end
    end

    // ------------------------------------------------------------------
    // Shared CRC engine: load pass, then verify pass
    // ------------------------------------------------------------------
    assign w_crc_init = w_start_ok || w_last_bit;
    assign w_crc_en   = w_shifting || (r_state == S_VERIFY);
    assign w_crc_bit  = (r_state == S_VERIFY) ? ccff_tail : r_shreg[WORD_W-1];

    ccff_crc16 u_crc (
        .clk        (prog_clk),
        .rst        (pReset),
        .i_init     (w_crc_init),
        .i_en       (w_crc_en),
        .i_bit      (w_crc_bit),
        .o_crc      (w_crc),
        .o_crc_next (w_crc_next)
    );

    // During verify the chain is closed into a ring through this mux.
    assign ccff_head     = (r_state == S_VERIFY) ? ccff_tail : r_shreg[WORD_W-1];
    assign cfg_ready     = w_ready;
    assign ccff_shift_en = r_shift_en;
    assign busy          = r_busy;
    assign done          = r_done;
    assign verify_ok     = r_verify_ok;
    assign verify_err    = r_verify_err;

    // w_crc is kept for visibility of the running CRC; not otherwise needed.
    logic w_unused;
    assign w_unused = ^w_crc;

endmodule
`default_nettype wire
